uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Byte-stream command parser sitting directly downstream of the 8-bit UART receiver. Consumes received bytes with their one-cycle ready strobe and decodes short ASCII command lines that set or toggle a 6-bit LED register. Emits a one-byte acknowledgement ('K' or 'E') toward a UART transmitter through a start/busy handshake. Intended to replace the direct byte-to-LED latch in the board top level; the top level keeps the active-low LED inversion.

## Interface
- TIMEOUT_CYCLES, 2700000, idle cycles after which a partial command is abandoned (100 ms at 27 MHz); counter width = $clog2(TIMEOUT_CYCLES+1)
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx_data  input  8  received byte; valid only when data_ready=1
- data_ready  input  1  one-cycle strobe per received byte
- tx_busy  input  1  transmitter busy; tx_start is not issued while high
- led_val  output  6  LED register (active-high; top inverts)
- cmd_valid  output  1  one-cycle pulse when a command is applied
- tx_data  output  8  reply byte; held stable from tx_start until the next tx_start
- tx_start  output  1  one-cycle transmit request

## Operation
- Command grammar: CMD HEX HEX EOL. CMD is 'L' (0x4C, load) or 'X' (0x58, XOR). HEX is 0-9, A-F, a-f. EOL is CR (0x0D) or LF (0x0A). Command letters are uppercase only.
- Value: 8-bit value = hi*16 + lo. Only bits [5:0] are used.
  - L: led_val <= value[5:0].
  - X: led_val <= led_val ^ value[5:0].
- States:
  - IDLE: CR/LF ignored, so CRLF and blank lines are harmless. 'L'/'X' latches the opcode and goes to HEX_HI. Any other byte goes to FLUSH.
  - HEX_HI: a hex digit latches the high nibble and goes to HEX_LO. A non-hex byte goes to FLUSH; EOL counts as a non-hex byte here.
  - HEX_LO: a hex digit latches the low nibble and goes to WAIT_EOL. A non-hex byte goes to FLUSH; EOL counts as a non-hex byte here.
  - WAIT_EOL: EOL applies the command, queues 'K' (0x4B) and goes to IDLE. Any other byte goes to FLUSH.
  - FLUSH: discard bytes until EOL, then queue 'E' (0x45) and go to IDLE. An EOL that itself caused the entry into FLUSH (from HEX_HI/HEX_LO) queues 'E' immediately and goes to IDLE.
- Timeout: the idle counter clears on every data_ready and counts while the state is not IDLE. On reaching TIMEOUT_CYCLES: go to IDLE silently, with no reply and no led_val change.
- Reply queue:
  - One-deep pending register (pend_valid, pend_byte).
  - A new reply while pending overwrites pend_byte; the older reply is dropped.
  - tx_start pulses when pend_valid=1 and tx_busy=0 and tx_start was 0 in the previous cycle. tx_data loads pend_byte at the same edge, and pend_valid clears.
- Reset values: led_val=0, cmd_valid=0, tx_start=0, tx_data=0, state=IDLE, pend_valid=0, timeout counter=0. Reset mid-command discards all partial state.

## Timing
- Bytes are sampled only in cycles with data_ready=1. Back-to-back strobes (every cycle) must be handled; there is no backpressure toward the receiver.
- EOL strobe in cycle N:
  - led_val takes its new value and cmd_valid=1 in cycle N+1, for one cycle.
  - pend_valid=1 in cycle N+1.
- tx_start earliest in cycle N+2, given tx_busy=0 in cycle N+1. If tx_busy is high, it is delayed to the first cycle after tx_busy falls.
- If a reply queue and a tx_start launch occur in the same cycle, pend_valid stays 1 with the new byte.
- Timeout fires in the cycle the counter reaches TIMEOUT_CYCLES after the last data_ready. The state is IDLE in the next cycle.
- Status of each byte: a byte arriving in the same cycle as the timeout takes precedence (counter clears, byte processed in current state).

## Test plan
- "L2A\r" -> led_val=6'h2A and cmd_valid pulse one cycle after the CR strobe; tx_start with tx_data=0x4B two cycles after.
- After "L2A\r", send "X0f\n" -> led_val=6'h25, reply 0x4B; then "LFF\r\n" -> led_val=6'h3F, one reply only (LF ignored).
- "LZ1\n", "Q\n", "L\n", "L123\n" -> led_val unchanged, each produces cmd_valid=0 and reply 0x45.
- "L3" then no bytes for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=100) -> no reply, led_val unchanged; then "L01\r" -> led_val=6'h01, reply 0x4B.
- Hold tx_busy=1, send "L05\r" then "QQ\r" -> no tx_start while busy; release -> exactly one tx_start with tx_data=0x45.
- Assert rst after "X1" mid-line, release, send "3\r" -> FLUSH path, reply 0x45, led_val=0; outputs all zero during reset.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Line-oriented ASCII command parser: "L hh EOL" loads, "X hh EOL" XORs a 6-bit LED register.
// Each finished line queues a one-byte reply ('K' or 'E') toward a UART transmitter.
module uart_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       data_ready,
  input  logic       tx_busy,
  output logic [5:0] led_val,
  output logic       cmd_valid,
  output logic [7:0] tx_data,
  output logic       tx_start
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE, S_HEX_HI, S_HEX_LO, S_WAIT_EOL, S_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_xor_q, op_xor_d;
  logic [5:0]    val_q, val_d;
  logic [5:0]    led_q, led_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_byte_q, pend_byte_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;

  logic       is_eol, is_cmd, is_hex;
  logic [3:0] nib;
  logic       timeout_hit;
  logic       reply_vld;
  logic [7:0] reply_byte;
  logic       launch;

  always_comb begin
    is_eol = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    is_cmd = (rx_data == 8'h4C) || (rx_data == 8'h58);
    is_hex = 1'b0;
    nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0] + 4'd9;
    end
  end

  // A byte arriving in the timeout cycle wins, so the hit requires no strobe.
  assign timeout_hit = (state_q != S_IDLE) && !data_ready &&
                       (cnt_q == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (data_ready) begin
      case (state_q)
        S_IDLE:     if (is_cmd) state_d = S_HEX_HI;
                    else if (!is_eol) state_d = S_FLUSH;
        S_HEX_HI:   if (is_hex) state_d = S_HEX_LO;
                    else if (is_eol) state_d = S_IDLE;
                    else state_d = S_FLUSH;
        S_HEX_LO:   if (is_hex) state_d = S_WAIT_EOL;
                    else if (is_eol) state_d = S_IDLE;
                    else state_d = S_FLUSH;
        S_WAIT_EOL: state_d = is_eol ? S_IDLE : S_FLUSH;
        S_FLUSH:    if (is_eol) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    op_xor_d    = op_xor_q;
    val_d       = val_q;
    led_d       = led_q;
    cmd_valid_d = 1'b0;
    reply_vld   = 1'b0;
    reply_byte  = CH_K;
    if (data_ready) begin
      case (state_q)
        S_IDLE:     if (is_cmd) op_xor_d = (rx_data == 8'h58);
        S_HEX_HI:   if (is_hex) val_d = {nib[1:0], 4'h0};
                    else if (is_eol) begin reply_vld = 1'b1; reply_byte = CH_E; end
        S_HEX_LO:   if (is_hex) val_d = {val_q[5:4], nib};
                    else if (is_eol) begin reply_vld = 1'b1; reply_byte = CH_E; end
        S_WAIT_EOL: if (is_eol) begin
                      cmd_valid_d = 1'b1;
                      led_d       = op_xor_q ? (led_q ^ val_q) : val_q;
                      reply_vld   = 1'b1;
                    end
        S_FLUSH:    if (is_eol) begin reply_vld = 1'b1; reply_byte = CH_E; end
        default:    reply_vld = 1'b0;
      endcase
    end

    cnt_d = (data_ready || state_q == S_IDLE || timeout_hit) ? '0 : cnt_q + CW'(1);

    // A reply queued in the launch cycle survives the launch and overwrites any older one.
    launch       = pend_valid_q && !tx_busy && !tx_start_q;
    tx_start_d   = launch;
    tx_data_d    = launch ? pend_byte_q : tx_data_q;
    pend_valid_d = reply_vld ? 1'b1 : (launch ? 1'b0 : pend_valid_q);
    pend_byte_d  = reply_vld ? reply_byte : pend_byte_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      op_xor_q     <= 1'b0;
      val_q        <= '0;
      led_q        <= '0;
      cmd_valid_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      op_xor_q     <= op_xor_d;
      val_q        <= val_d;
      led_q        <= led_d;
      cmd_valid_q  <= cmd_valid_d;
      pend_valid_q <= pend_valid_d;
      pend_byte_q  <= pend_byte_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
    end
  end

  assign led_val   = led_q;
  assign cmd_valid = cmd_valid_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed table, timing/timeout/busy/reset sequences and random lines,
// checked against a line-buffer reference model and an expected reply queue.
module tb_uart_cmd_parser;
  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       data_ready = 1'b0;
  logic       tx_busy = 1'b0;
  logic [5:0] led_val;
  logic       cmd_valid;
  logic [7:0] tx_data;
  logic       tx_start;

  always #5 clk = ~clk;

  uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .data_ready(data_ready), .tx_busy(tx_busy),
    .led_val(led_val), .cmd_valid(cmd_valid), .tx_data(tx_data), .tx_start(tx_start)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] line_q[$];
  logic [5:0] m_led = 6'h00;
  int         m_cmds = 0;
  int         gap = 0;
  int         n_tx = 0;
  int         n_cv = 0;
  logic [7:0] last_tx = 8'h00;
  logic       busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_hex_c(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic int hexval(input logic [7:0] b);
    if (b <= 8'h39) return int'(b) - 48;
    if (b <= 8'h46) return int'(b) - 65 + 10;
    return int'(b) - 97 + 10;
  endfunction

  // Reference: buffer a line, judge it as a whole when its terminator arrives.
  task automatic model_byte(input logic [7:0] b, output logic cv);
    int v;
    logic [5:0] v6;
    cv = 1'b0;
    if (gap > T) line_q.delete();
    if (b == 8'h0D || b == 8'h0A) begin
      if (line_q.size() > 0) begin
        if (line_q.size() == 3 && (line_q[0] == 8'h4C || line_q[0] == 8'h58) &&
            is_hex_c(line_q[1]) && is_hex_c(line_q[2])) begin
          v  = hexval(line_q[1]) * 16 + hexval(line_q[2]);
          v6 = v[5:0];
          m_led = (line_q[0] == 8'h4C) ? v6 : (m_led ^ v6);
          cv = 1'b1;
          m_cmds++;
          exp_q.push_back(8'h4B);
        end else begin
          exp_q.push_back(8'h45);
        end
        line_q.delete();
      end
    end else begin
      line_q.push_back(b);
    end
    gap = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the strobe dropped.
  task automatic send_byte(input logic [7:0] b);
    logic cv;
    rx_data = b;
    data_ready = 1'b1;
    @(posedge clk);
    model_byte(b, cv);
    #1;
    data_ready = 1'b0;
    chk("led_val", led_val, m_led);
    chk("cmd_valid", cmd_valid, cv);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
    gap += n;
  endtask

  // '~' stands for CR and '|' for LF in these strings.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] b;
      b = s[i];
      if (b == 8'h7E) b = 8'h0D;
      else if (b == 8'h7C) b = 8'h0A;
      send_byte(b);
    end
  endtask

  task automatic model_reset();
    m_led = 6'h00;
    line_q.delete();
    exp_q.delete();
    gap = 0;
  endtask

  always @(negedge clk) begin
    if (cmd_valid) n_cv++;
    if (tx_start) begin
      n_tx++;
      last_tx = tx_data;
      chk("tx_start_while_busy", busy_prev, 1'b0);
      chk("tx_reply_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) chk("tx_data", tx_data, exp_q.pop_front());
    end
    busy_prev = tx_busy;
  end

  typedef struct {
    string      s;
    logic [5:0] led;
    int         n_rep;
    logic [7:0] rep;
  } vec_t;

  vec_t tbl[12];

  task automatic set_vec(input int i, input string s, input logic [5:0] led, input int n, input logic [7:0] rep);
    tbl[i].s = s; tbl[i].led = led; tbl[i].n_rep = n; tbl[i].rep = rep;
  endtask

  initial begin
    int n0;
    string hs;
    logic [7:0] bq[$];
    hs = "0123456789ABCDEFabcdef";

    set_vec(0,  "X0f|",   6'h25, 1, 8'h4B);
    set_vec(1,  "LFF~|",  6'h3F, 1, 8'h4B);
    set_vec(2,  "LZ1|",   6'h3F, 1, 8'h45);
    set_vec(3,  "Q|",     6'h3F, 1, 8'h45);
    set_vec(4,  "L|",     6'h3F, 1, 8'h45);
    set_vec(5,  "L123|",  6'h3F, 1, 8'h45);
    set_vec(6,  "~|~",    6'h3F, 0, 8'h00);
    set_vec(7,  "x12~",   6'h3F, 1, 8'h45);
    set_vec(8,  "L3a~",   6'h3A, 1, 8'h4B);
    set_vec(9,  "X7F~",   6'h05, 1, 8'h4B);
    set_vec(10, "LG0~",   6'h05, 1, 8'h45);
    set_vec(11, "la0~",   6'h05, 1, 8'h45);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_led_val", led_val, 6'h00);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    idle(2);

    // First command: exact latency of led/cmd_valid and of the reply.
    send_str("L2A~");
    chk("l2a_led", led_val, 6'h2A);
    chk("l2a_tx_start_n1", tx_start, 1'b0);
    @(posedge clk); #1;
    chk("l2a_tx_start_n2", tx_start, 1'b1);
    chk("l2a_tx_data", tx_data, 8'h4B);
    chk("l2a_cmd_valid_n2", cmd_valid, 1'b0);
    @(posedge clk); #1;
    chk("l2a_tx_start_n3", tx_start, 1'b0);
    gap += 2;

    for (int i = 0; i < 12; i++) begin
      n0 = n_tx;
      send_str(tbl[i].s);
      idle(4);
      chk($sformatf("tbl%0d_led", i), led_val, tbl[i].led);
      chk($sformatf("tbl%0d_replies", i), n_tx - n0, tbl[i].n_rep);
      if (tbl[i].n_rep > 0) chk($sformatf("tbl%0d_reply", i), last_tx, tbl[i].rep);
    end

    // Timeout: long gap abandons the partial line, gap of exactly T does not.
    n0 = n_tx;
    send_str("L3"); idle(T + 10); send_str("L01~"); idle(4);
    chk("to_long_led", led_val, 6'h01);
    chk("to_long_replies", n_tx - n0, 1);
    chk("to_long_reply", last_tx, 8'h4B);
    n0 = n_tx;
    send_str("L3"); idle(T - 5); send_str("F~"); idle(4);
    chk("to_short_led", led_val, 6'h3F);
    chk("to_short_reply", last_tx, 8'h4B);
    send_str("X0"); idle(T); send_str("1~"); idle(4);
    chk("to_edge_led", led_val, 6'h3E);
    chk("to_edge_reply", last_tx, 8'h4B);
    send_str("X0"); idle(T + 1); send_str("1~"); idle(4);
    chk("to_past_led", led_val, 6'h3E);
    chk("to_past_reply", last_tx, 8'h45);
    chk("to_replies", n_tx - n0, 3);

    // Busy transmitter: later reply overwrites the pending one.
    tx_busy = 1'b1;
    n0 = n_tx;
    send_str("L05~"); send_str("QQ~");
    exp_q.delete();
    exp_q.push_back(8'h45);
    idle(10);
    chk("busy_no_tx", n_tx - n0, 0);
    chk("busy_led", led_val, 6'h05);
    tx_busy = 1'b0;
    idle(6);
    chk("busy_release_tx", n_tx - n0, 1);
    chk("busy_release_data", last_tx, 8'h45);

    // Random lines, back-to-back and gapped, checked by the model.
    for (int l = 0; l < 150; l++) begin
      int kind;
      bq.delete();
      kind = $urandom_range(0, 5);
      if (kind <= 2) begin
        bq.push_back($urandom_range(0, 1) ? 8'h4C : 8'h58);
        bq.push_back(hs[$urandom_range(0, 21)]);
        bq.push_back(hs[$urandom_range(0, 21)]);
        if (kind == 2) bq[$urandom_range(0, 2)] = 8'($urandom_range(0, 255));
      end else if (kind == 3) begin
        repeat ($urandom_range(1, 5)) bq.push_back(8'($urandom_range(0, 255)));
      end
      bq.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
      foreach (bq[j]) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send_byte(bq[j]);
      end
    end
    idle(6);

    // Reset mid-line discards the partial command.
    send_str("X1");
    rst = 1'b1;
    #3;
    chk("mid_rst_led_val", led_val, 6'h00);
    chk("mid_rst_cmd_valid", cmd_valid, 1'b0);
    chk("mid_rst_tx_start", tx_start, 1'b0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    n0 = n_tx;
    send_str("3~");
    idle(4);
    chk("post_rst_led", led_val, 6'h00);
    chk("post_rst_replies", n_tx - n0, 1);
    chk("post_rst_reply", last_tx, 8'h45);

    chk("replies_drained", exp_q.size(), 0);
    chk("cmd_valid_pulses", n_cv, m_cmds);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
